// File: rtl/pproc_bus_gba.sv
// Shared GBA peripheral-bus definitions: register map entries and sound FIFO sizing.
package pproc_bus_gba;

  typedef struct packed {
    logic [27:0] adr;
    logic [4:0]  upper;
    logic [4:0]  lower;
    logic [31:0] def_val;
  } regmap_type;

  localparam regmap_type FIFO_A = '{adr: 28'h40000A0, upper: 5'd31, lower: 5'd0, def_val: 32'h0};
  localparam regmap_type FIFO_B = '{adr: 28'h40000A4, upper: 5'd31, lower: 5'd0, def_val: 32'h0};

  localparam int SND_FIFO_DEPTH      = 8;
  localparam int SND_FIFO_DMA_THRESH = 4;

endpackage

// File: rtl/gba_sound_fifo_mem.sv
// Word storage for the DirectSound FIFO: one synchronous write port, one synchronous
// read port with write-to-read forwarding so a freshly written head word is visible next cycle.
module gba_sound_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset; contents are only read once level says a slot is valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gba_sound_fifo.sv
// DirectSound sample FIFO for one GBA channel: word pushes from the bus, byte pops on timer ticks.
// Define GBA_SOUND_FIFO_UNDERRUN_EN to build the sticky underrun flag; otherwise it reads 0.
module gba_sound_fifo
  import pproc_bus_gba::*;
#(
  parameter logic [27:0] FIFO_ADR    = 28'h0,
  parameter int          DEPTH_WORDS = SND_FIFO_DEPTH,
  parameter int          DMA_THRESH  = SND_FIFO_DMA_THRESH,
  localparam int         PTR_W       = $clog2(DEPTH_WORDS),
  localparam int         LVL_W       = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gb_on,
  input  logic [31:0]      gb_bus_din,
  output logic [31:0]      gb_bus_dout,
  input  logic [27:0]      gb_bus_adr,
  input  logic             gb_bus_rnw,
  input  logic             gb_bus_ena,
  input  logic [3:0]       gb_bus_be,
  input  logic             tick0,
  input  logic             tick1,
  input  logic             timer_sel,
  input  logic             fifo_reset,
  output logic [7:0]       sample,
  output logic             dma_req,
  output logic [LVL_W-1:0] level,
  output logic             underrun
);

  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH_WORDS);
  localparam logic [LVL_W-1:0] THRESH_LVL = LVL_W'(DMA_THRESH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       rd_byte_q, rd_byte_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       sample_q, sample_d;
  logic             dma_req_q, dma_req_d;

  logic        push, tk, pop, free, accept, clr, mem_we;
  logic [31:0] head_word;
  logic [7:0]  head_byte;

  // Write-only register: the read bus is wired-OR, so contribute nothing.
  assign gb_bus_dout = '0;

  assign push   = gb_on & gb_bus_ena & ~gb_bus_rnw & (gb_bus_adr == FIFO_ADR) & (|gb_bus_be);
  assign tk     = gb_on & (timer_sel ? tick1 : tick0);
  assign clr    = gb_on & fifo_reset;
  assign pop    = tk & (level_q != '0);
  assign free   = pop & (rd_byte_q == 2'd3);
  assign accept = push & ((level_q != FULL_LVL) | free);
  assign mem_we = accept & ~clr;

  always_comb begin
    case (rd_byte_q)
      2'd0:    head_byte = head_word[7:0];
      2'd1:    head_byte = head_word[15:8];
      2'd2:    head_byte = head_word[23:16];
      default: head_byte = head_word[31:24];
    endcase
  end

  // NOTE: every next-state signal gets its hold value first so no branch can infer a latch.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_byte_d = rd_byte_q;
    level_d   = level_q;
    sample_d  = sample_q;
    dma_req_d = 1'b0;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_byte_d = '0;
      level_d   = '0;
      sample_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        sample_d  = head_byte;
        rd_byte_d = rd_byte_q + 2'd1;
      end
      if (free) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({accept, free})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      dma_req_d = free & (level_d <= THRESH_LVL);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_byte_q <= '0;
      level_q   <= '0;
      sample_q  <= '0;
      dma_req_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_byte_q <= rd_byte_d;
      level_q   <= level_d;
      sample_q  <= sample_d;
      dma_req_q <= dma_req_d;
    end
  end

  // Reading at the next head pointer keeps the head word prefetched for 1-cycle sample latency.
  gba_sound_fifo_mem #(
    .DEPTH (DEPTH_WORDS),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (gb_bus_din),
    .raddr_i (rd_ptr_d),
    .rdata_o (head_word)
  );

`ifdef GBA_SOUND_FIFO_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (clr) begin
      underrun_q <= 1'b0;
    end else if (tk && (level_q == '0)) begin
      underrun_q <= 1'b1;
    end
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  assign sample  = sample_q;
  assign dma_req = dma_req_q;
  assign level   = level_q;

endmodule

// File: tb/tb_gba_sound_fifo.sv
// Self-checking bench for gba_sound_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_gba_sound_fifo;
  import pproc_bus_gba::*;

  localparam logic [27:0] ADR    = FIFO_A.adr;
  localparam int          DEPTH  = 8;
  localparam int          THRESH = 4;

  logic        clk = 1'b0;
  logic        reset, gb_on;
  logic [31:0] gb_bus_din, gb_bus_dout;
  logic [27:0] gb_bus_adr;
  logic        gb_bus_rnw, gb_bus_ena;
  logic [3:0]  gb_bus_be;
  logic        tick0, tick1, timer_sel, fifo_reset;
  logic [7:0]  sample;
  logic        dma_req, underrun;
  logic [3:0]  level;

  gba_sound_fifo #(
    .FIFO_ADR    (ADR),
    .DEPTH_WORDS (DEPTH),
    .DMA_THRESH  (THRESH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gb_on       (gb_on),
    .gb_bus_din  (gb_bus_din),
    .gb_bus_dout (gb_bus_dout),
    .gb_bus_adr  (gb_bus_adr),
    .gb_bus_rnw  (gb_bus_rnw),
    .gb_bus_ena  (gb_bus_ena),
    .gb_bus_be   (gb_bus_be),
    .tick0       (tick0),
    .tick1       (tick1),
    .timer_sel   (timer_sel),
    .fifo_reset  (fifo_reset),
    .sample      (sample),
    .dma_req     (dma_req),
    .level       (level),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] mq[$];
  int          m_rdb;
  logic [7:0]  m_sample;
  logic        m_und;
  logic        m_dma;
  int          dma_seen;
  int          dma_lvls[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference behaviour: a queue of whole words plus a byte cursor into the front word.
  task automatic model_update();
    logic [31:0] w;
    logic        tk, push, freed;
    m_dma = 1'b0;
    if (reset) begin
      mq.delete(); m_rdb = 0; m_sample = 8'h00; m_und = 1'b0;
      return;
    end
    if (!gb_on) return;
    if (fifo_reset) begin
      mq.delete(); m_rdb = 0; m_sample = 8'h00; m_und = 1'b0;
      return;
    end
    tk    = timer_sel ? tick1 : tick0;
    push  = gb_bus_ena && !gb_bus_rnw && (gb_bus_adr == ADR) && (gb_bus_be != 4'h0);
    freed = 1'b0;
    if (tk) begin
      if (mq.size() > 0) begin
        w        = mq[0];
        m_sample = w[m_rdb*8 +: 8];
        if (m_rdb == 3) begin
          void'(mq.pop_front());
          m_rdb = 0;
          freed = 1'b1;
        end else begin
          m_rdb++;
        end
      end else begin
`ifdef GBA_SOUND_FIFO_UNDERRUN_EN
        m_und = 1'b1;
`endif
      end
    end
    if (push && mq.size() < DEPTH) mq.push_back(gb_bus_din);
    if (freed && mq.size() <= THRESH) m_dma = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("sample", 32'(sample), 32'(m_sample));
    check("level", 32'(level), 32'(mq.size()));
    check("dma_req", 32'(dma_req), 32'(m_dma));
    check("underrun", 32'(underrun), 32'(m_und));
    if (dma_req) begin
      dma_seen++;
      dma_lvls.push_back(int'(level));
    end
  endtask

  task automatic idle_inputs();
    gb_bus_ena = 1'b0; gb_bus_rnw = 1'b1; gb_bus_be = 4'h0; gb_bus_adr = ADR;
    tick0 = 1'b0; tick1 = 1'b0; fifo_reset = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] d);
    gb_bus_ena = 1'b1; gb_bus_rnw = 1'b0; gb_bus_be = 4'hF; gb_bus_adr = ADR; gb_bus_din = d;
  endtask

  task automatic push_word(input logic [31:0] d);
    set_push(d); step(); idle_inputs();
  endtask

  task automatic tick_sel(input logic which);
    if (which) tick1 = 1'b1; else tick0 = 1'b1;
    step(); idle_inputs();
  endtask

  function automatic logic [31:0] fill_word(input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*k); b1 = 8'(4*k + 1); b2 = 8'(4*k + 2); b3 = 8'(4*k + 3);
    return {b3, b2, b1, b0};
  endfunction

  initial begin
    logic [7:0] exp_b;
    gb_on = 1'b1; timer_sel = 1'b0; gb_bus_din = '0; reset = 1'b1;
    idle_inputs();
    step(); step();
    reset = 1'b0;
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_dma", 32'(dma_req), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("bus_dout", gb_bus_dout, 32'h0);

    // Basic playback
    push_word(32'h04030201);
    check("bp_level1", 32'(level), 32'd1);
    dma_seen = 0;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'(i + 1);
      tick_sel(1'b0);
      check("bp_sample", 32'(sample), 32'(exp_b));
    end
    check("bp_level0", 32'(level), 32'd0);
    check("bp_dma_cnt", 32'(dma_seen), 32'd1);

    // Fill to full: ninth word dropped
    for (int k = 0; k < 9; k++) push_word(fill_word(k));
    check("full_level", 32'(level), 32'd8);
    dma_seen = 0; dma_lvls.delete();
    for (int i = 0; i < 32; i++) begin
      exp_b = 8'(i);
      tick_sel(1'b0);
      check("drain_sample", 32'(sample), 32'(exp_b));
    end
    check("drain_dma_cnt", 32'(dma_seen), 32'd5);
    for (int i = 0; i < dma_lvls.size(); i++) check("drain_dma_lvl", 32'(dma_lvls[i]), 32'(4 - i));

    // Underrun: sample holds
    tick_sel(1'b0);
    check("ur_sample", 32'(sample), 32'h1F);
`ifdef GBA_SOUND_FIFO_UNDERRUN_EN
    check("ur_flag", 32'(underrun), 32'd1);
`else
    check("ur_flag", 32'(underrun), 32'd0);
`endif

    // Full boundary: push accepted while the head word is freed
    fifo_reset = 1'b1; step(); idle_inputs();
    for (int k = 0; k < 8; k++) push_word(fill_word(k + 16));
    for (int i = 0; i < 3; i++) tick_sel(1'b0);
    set_push(32'hDEADBEEF); tick0 = 1'b1; step(); idle_inputs();
    check("fb_level", 32'(level), 32'd8);
    check("fb_sample", 32'(sample), 32'h43);
    check("fb_dma", 32'(dma_req), 32'd0);

    // Timer select
    timer_sel = 1'b1;
    tick_sel(1'b0);
    check("ts_hold", 32'(sample), 32'h43);
    tick_sel(1'b1);
    check("ts_pop", 32'(sample), 32'h44);
    timer_sel = 1'b0;

    // fifo_reset beats a simultaneous push and tick
    fifo_reset = 1'b1; step(); idle_inputs();
    for (int k = 0; k < 5; k++) push_word(fill_word(k));
    check("fr_pre_level", 32'(level), 32'd5);
    set_push(32'h12345678); tick0 = 1'b1; fifo_reset = 1'b1; step(); idle_inputs();
    check("fr_level", 32'(level), 32'd0);
    check("fr_sample", 32'(sample), 32'd0);
    check("fr_dma", 32'(dma_req), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      gb_on      = ($urandom_range(0, 19) != 0);
      fifo_reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) timer_sel = ~timer_sel;
      tick0      = ($urandom_range(0, 3) == 0);
      tick1      = ($urandom_range(0, 3) == 0);
      gb_bus_ena = ($urandom_range(0, 9) == 0);
      gb_bus_rnw = ($urandom_range(0, 7) == 0);
      gb_bus_adr = ($urandom_range(0, 5) == 0) ? FIFO_B.adr : ADR;
      gb_bus_be  = 4'($urandom_range(0, 15));
      gb_bus_din = $urandom;
      step();
    end
    reset = 1'b0; gb_on = 1'b1; idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
